cache_dir_responder: RTL

CACHE_DIR_RESPONDER -- requirements
Module: cache_dir_responder

---
 rtl/cache_dir_responder_pkg.sv | 39 +++
 rtl/cache_dir_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_dir_responder_pkg.sv
// Shared cache/directory definitions: directory opcodes, coherence states,
// source identifiers and the responder FSM encoding.
package cache_dir_responder_pkg;

  typedef enum logic [2:0] {
    OP_NOOP     = 3'd0,
    OP_NOOP_ALT = 3'd1,
    OP_REPLY    = 3'd2,
    OP_RD       = 3'd3,
    OP_WR       = 3'd4,
    OP_INV      = 3'd5,
    OP_UPD      = 3'd6,
    OP_RWITM    = 3'd7
  } dir_op_e;

  typedef enum logic [1:0] {
    CS_I   = 2'd0,
    CS_S   = 2'd1,
    CS_M   = 2'd2,
    CS_RSV = 2'd3
  } coh_state_e;

  localparam logic [1:0] SRC_ICACHE = 2'd1;
  localparam logic [1:0] SRC_DCACHE = 2'd2;
  localparam logic [1:0] SRC_MEM    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOOKUP  = 2'd1,
    ST_COMPARE = 2'd2,
    ST_SEND    = 2'd3
  } rsp_fsm_e;

  // Opcode 1 is reserved and behaves exactly like NOOP.
  function automatic logic op_is_noop(input logic [2:0] op);
    return (op == OP_NOOP) || (op == OP_NOOP_ALT);
  endfunction

endpackage

// File: rtl/cache_dir_responder.sv
// Cache-side responder for directory requests: looks the line up in the
// cache array, updates its coherence state/data and replies to the directory.
module cache_dir_responder
  import cache_dir_responder_pkg::*;
#(
  parameter int unsigned CL_SIZE  = 128,
  parameter logic [1:0]  CACHE_ID = SRC_DCACHE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [31:0]        req_addr,
  input  logic [CL_SIZE-1:0] req_data,
  input  logic [1:0]         req_src,
  input  logic [1:0]         req_dest,
  output logic               arr_rd_en,
  output logic [31:0]        arr_rd_addr,
  input  logic               arr_hit,
  input  logic [1:0]         arr_state,
  input  logic [CL_SIZE-1:0] arr_data,
  output logic               arr_wr_en,
  output logic [31:0]        arr_wr_addr,
  output logic [1:0]         arr_wr_state,
  output logic               arr_wr_data_en,
  output logic [CL_SIZE-1:0] arr_wr_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2:0]         rsp_op,
  output logic [31:0]        rsp_addr,
  output logic [CL_SIZE-1:0] rsp_data,
  output logic [1:0]         rsp_src,
  output logic [1:0]         rsp_dest
);

  localparam logic [CL_SIZE-1:0] LINE_ZERO = {CL_SIZE{1'b0}};

  rsp_fsm_e           fsm_r;
  logic [2:0]         op_r;
  logic [31:0]        addr_r;
  logic [CL_SIZE-1:0] data_r;
  logic [1:0]         src_r;
  logic [1:0]         dest_r;

  logic               req_ready_r;
  logic               arr_rd_en_r;
  logic [31:0]        arr_rd_addr_r;
  logic               rsp_valid_r;
  logic [2:0]         rsp_op_r;
  logic [31:0]        rsp_addr_r;
  logic [CL_SIZE-1:0] rsp_data_r;
  logic [1:0]         rsp_src_r;
  logic [1:0]         rsp_dest_r;

  logic               hit_s;
  logic               wr_en_s;
  logic [1:0]         wr_state_s;
  logic               wr_data_en_s;
  logic [CL_SIZE-1:0] wr_data_s;
  logic               reply_s;
  logic [2:0]         reply_op_s;
  logic [CL_SIZE-1:0] reply_data_s;
  logic               wr_active_s;
  logic               unused_s;

  // Decode the latched request against the lookup result into write and reply actions.
  always_comb begin
    hit_s        = arr_hit && (arr_state != CS_RSV);
    wr_en_s      = 1'b0;
    wr_state_s   = CS_I;
    wr_data_en_s = 1'b0;
    wr_data_s    = LINE_ZERO;
    reply_s      = 1'b0;
    reply_op_s   = OP_NOOP;
    reply_data_s = LINE_ZERO;
    case (op_r)
      OP_REPLY: begin
        wr_en_s      = 1'b1;
        wr_state_s   = CS_S;
        wr_data_en_s = 1'b1;
        wr_data_s    = data_r;
      end
      OP_WR: begin
        wr_en_s      = 1'b1;
        wr_state_s   = CS_M;
        wr_data_en_s = 1'b1;
        wr_data_s    = data_r;
      end
      OP_RD: begin
        reply_s    = 1'b1;
        reply_op_s = OP_REPLY;
        if (hit_s) begin
          reply_data_s = arr_data;
          if (arr_state == CS_M) begin
            wr_en_s    = 1'b1;
            wr_state_s = CS_S;
          end else begin
            wr_en_s = 1'b0;
          end
        end else begin
          reply_data_s = LINE_ZERO;
        end
      end
      OP_RWITM: begin
        reply_s    = 1'b1;
        reply_op_s = OP_REPLY;
        if (hit_s) begin
          reply_data_s = arr_data;
          wr_en_s      = 1'b1;
          wr_state_s   = CS_I;
        end else begin
          reply_data_s = LINE_ZERO;
        end
      end
      OP_INV: begin
        reply_s    = 1'b1;
        reply_op_s = OP_INV;
        if (hit_s) begin
          wr_en_s    = 1'b1;
          wr_state_s = CS_I;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      OP_UPD: begin
        reply_s    = 1'b1;
        reply_op_s = OP_UPD;
        if (hit_s) begin
          wr_en_s      = 1'b1;
          wr_state_s   = arr_state;
          wr_data_en_s = 1'b1;
          wr_data_s    = data_r;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      default: begin
        wr_en_s = 1'b0;
        reply_s = 1'b0;
      end
    endcase
  end

  // The array write must land in the COMPARE cycle itself; rst suppresses it immediately.
  assign wr_active_s    = (fsm_r == ST_COMPARE) && !rst && wr_en_s;
  assign arr_wr_en      = wr_active_s;
  assign arr_wr_addr    = wr_active_s ? addr_r : 32'd0;
  assign arr_wr_state   = wr_active_s ? wr_state_s : 2'd0;
  assign arr_wr_data_en = wr_active_s && wr_data_en_s;
  assign arr_wr_data    = (wr_active_s && wr_data_en_s) ? wr_data_s : LINE_ZERO;

  // Request, lookup and reply sequencing with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r         <= ST_IDLE;
      op_r          <= 3'd0;
      addr_r        <= 32'd0;
      data_r        <= LINE_ZERO;
      src_r         <= 2'd0;
      dest_r        <= 2'd0;
      req_ready_r   <= 1'b1;
      arr_rd_en_r   <= 1'b0;
      arr_rd_addr_r <= 32'd0;
      rsp_valid_r   <= 1'b0;
      rsp_op_r      <= 3'd0;
      rsp_addr_r    <= 32'd0;
      rsp_data_r    <= LINE_ZERO;
      rsp_src_r     <= 2'd0;
      rsp_dest_r    <= 2'd0;
    end else begin
      case (fsm_r)
        ST_IDLE: begin
          if (req_valid && !op_is_noop(req_op)) begin
            op_r          <= req_op;
            addr_r        <= req_addr;
            data_r        <= req_data;
            src_r         <= req_src;
            dest_r        <= req_dest;
            req_ready_r   <= 1'b0;
            arr_rd_en_r   <= 1'b1;
            arr_rd_addr_r <= req_addr;
            fsm_r         <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          arr_rd_en_r   <= 1'b0;
          arr_rd_addr_r <= 32'd0;
          fsm_r         <= ST_COMPARE;
        end
        ST_COMPARE: begin
          if (reply_s) begin
            rsp_valid_r <= 1'b1;
            rsp_op_r    <= reply_op_s;
            rsp_addr_r  <= addr_r;
            rsp_data_r  <= reply_data_s;
            rsp_src_r   <= CACHE_ID;
            rsp_dest_r  <= src_r;
            fsm_r       <= ST_SEND;
          end else begin
            req_ready_r <= 1'b1;
            fsm_r       <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_op_r    <= 3'd0;
            rsp_addr_r  <= 32'd0;
            rsp_data_r  <= LINE_ZERO;
            rsp_src_r   <= 2'd0;
            rsp_dest_r  <= 2'd0;
            req_ready_r <= 1'b1;
            fsm_r       <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          arr_rd_en_r <= 1'b0;
          req_ready_r <= 1'b1;
          fsm_r       <= ST_IDLE;
        end
      endcase
    end
  end

  // The directory's destination field is captured with the request but no reply rule uses it.
  assign unused_s = ^dest_r;

  assign req_ready   = req_ready_r;
  assign arr_rd_en   = arr_rd_en_r;
  assign arr_rd_addr = arr_rd_addr_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_op      = rsp_op_r;
  assign rsp_addr    = rsp_addr_r;
  assign rsp_data    = rsp_data_r;
  assign rsp_src     = rsp_src_r;
  assign rsp_dest    = rsp_dest_r;

endmodule
